// File: rtl/bnn_pkg.sv
// -----------------------------------------------------------------------------
// bnn_pkg
// Shared definitions for the binary neural network vote path. The neuron core
// and the vote accumulator both take their default sizing and the accumulator
// state encoding from this package so the two stay in step.
//   NUM_NEURONS : neuron output bits produced per sample
//   FRAME_LEN   : samples accumulated before a decision is made (2..15)
//   CNT_W       : vote/sample counter width, wide enough to hold FRAME_LEN
//   CLS_W       : width of a neuron index
//   state_t     : accumulator FSM states
// -----------------------------------------------------------------------------
package bnn_pkg;

  localparam int NUM_NEURONS = 4;
  localparam int FRAME_LEN   = 8;
  localparam int CNT_W       = $clog2(FRAME_LEN + 1);
  localparam int CLS_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

  // ACCUM collects samples; HOLD presents a decision until it is consumed.
  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/bnn_argmax.sv
// -----------------------------------------------------------------------------
// bnn_argmax
// Purely combinational argmax over the per-neuron vote counters.
//   votes     : packed vector of NUM_NEURONS counters, each CNT_W bits
//   win_class : index of the largest counter, lowest index on equal counts
//   win_count : value of that largest counter
//   win_tie   : 1 when some other neuron holds the same count as the winner
// -----------------------------------------------------------------------------
module bnn_argmax #(
  parameter int NUM_NEURONS = bnn_pkg::NUM_NEURONS,
  parameter int CNT_W       = bnn_pkg::CNT_W,
  parameter int CLS_W       = bnn_pkg::CLS_W
) (
  input  logic [NUM_NEURONS-1:0][CNT_W-1:0] votes,
  output logic [CLS_W-1:0]                  win_class,
  output logic [CNT_W-1:0]                  win_count,
  output logic                              win_tie
);

  int         best_idx;
  logic [CNT_W-1:0] best_cnt;

  // Strict greater-than keeps the earliest index on equal counts, so the lowest
  // index wins a tie. A second sweep then flags any other neuron matching the
  // winning count; with all-zero votes every neuron matches, which reports a tie.
  always_comb begin
    best_idx = 0;
    best_cnt = votes[0];
    for (int i = 1; i < NUM_NEURONS; i++) begin
      if (votes[i] > best_cnt) begin
        best_cnt = votes[i];
        best_idx = i;
      end
    end
    win_tie = 1'b0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      if ((i != best_idx) && (votes[i] == best_cnt)) begin
        win_tie = 1'b1;
      end
    end
  end

  assign win_class = CLS_W'(best_idx);
  assign win_count = best_cnt;

endmodule

// File: rtl/bnn_vote_accumulator.sv
// -----------------------------------------------------------------------------
// bnn_vote_accumulator
// Counts, per neuron, how many samples of a FRAME_LEN-sample frame had that
// neuron fire, then presents the most-voted neuron as a decision and holds it
// until the consumer takes it.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : synchronous abort of the current frame or pending decision
//   in_valid / in_ready / in_bits    : sample input handshake
//   out_valid / out_ready            : decision output handshake
//   out_class / out_count / out_tie  : winning neuron, its votes, tie flag
// -----------------------------------------------------------------------------
module bnn_vote_accumulator #(
  parameter int NUM_NEURONS = bnn_pkg::NUM_NEURONS,
  parameter int FRAME_LEN   = bnn_pkg::FRAME_LEN,
  parameter int CNT_W       = $clog2(FRAME_LEN + 1),
  parameter int CLS_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUM_NEURONS-1:0] in_bits,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CLS_W-1:0]       out_class,
  output logic [CNT_W-1:0]       out_count,
  output logic                   out_tie
);

  import bnn_pkg::*;

  state_t                           state;
  logic [NUM_NEURONS-1:0][CNT_W-1:0] votes;
  logic [NUM_NEURONS-1:0][CNT_W-1:0] votes_next;
  logic [CNT_W-1:0]                 sample_cnt;
  logic                             accept;
  logic                             last_beat;
  logic [CLS_W-1:0]                 arg_class;
  logic [CNT_W-1:0]                 arg_count;
  logic                             arg_tie;

  // Handshake flags depend on the state register alone, so out_ready never
  // reaches in_ready combinationally.
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);

  assign accept    = in_valid && in_ready;
  assign last_beat = accept && (sample_cnt == CNT_W'(FRAME_LEN - 1));

  // Vote vector as it will stand after the current beat. The argmax looks at
  // this value so the decision registered on the last beat already includes it.
  always_comb begin
    votes_next = votes;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      votes_next[i] = votes[i] + CNT_W'(in_bits[i]);
    end
  end

  bnn_argmax #(
    .NUM_NEURONS (NUM_NEURONS),
    .CNT_W       (CNT_W),
    .CLS_W       (CLS_W)
  ) u_argmax (
    .votes     (votes_next),
    .win_class (arg_class),
    .win_count (arg_count),
    .win_tie   (arg_tie)
  );

  // Frame FSM, counters and decision registers. clear outranks every other
  // event. Decision outputs are captured on the last beat and held through
  // HOLD; they read zero whenever the block is accumulating.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ACCUM;
      votes      <= '0;
      sample_cnt <= '0;
      out_class  <= '0;
      out_count  <= '0;
      out_tie    <= 1'b0;
    end else if (clear) begin
      state      <= ACCUM;
      votes      <= '0;
      sample_cnt <= '0;
      out_class  <= '0;
      out_count  <= '0;
      out_tie    <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            votes      <= votes_next;
            sample_cnt <= sample_cnt + CNT_W'(1);
            if (last_beat) begin
              state     <= HOLD;
              out_class <= arg_class;
              out_count <= arg_count;
              out_tie   <= arg_tie;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state      <= ACCUM;
            votes      <= '0;
            sample_cnt <= '0;
            out_class  <= '0;
            out_count  <= '0;
            out_tie    <= 1'b0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_vote_accumulator.sv
// -----------------------------------------------------------------------------
// tb_bnn_vote_accumulator
// Self-checking bench for bnn_vote_accumulator with the default sizing
// (4 neurons, 8-sample frames). A small vote model builds the expected decision
// for every completed frame and queues it; each scenario task pops the queue
// when the block presents a decision and compares against it.
// -----------------------------------------------------------------------------
module tb_bnn_vote_accumulator;

  typedef struct packed {
    logic [1:0] cls;
    logic [3:0] cnt;
    logic       tie;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_bits;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_class;
  logic [3:0] out_count;
  logic       out_tie;

  int   tests_run;
  int   tests_failed;
  exp_t sb[$];
  int   model_votes[4];
  int   model_cnt;

  bnn_vote_accumulator dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bits   (in_bits),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_count (out_count),
    .out_tie   (out_tie)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model_decision();
    exp_t e;
    int   mx;
    int   hits;
    mx = 0;
    for (int i = 0; i < 4; i++) if (model_votes[i] > mx) mx = model_votes[i];
    hits = 0;
    e.cls = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (model_votes[i] == mx) begin
        hits++;
        e.cls = 2'(i);
      end
    end
    e.cnt = 4'(mx);
    e.tie = (hits > 1);
    return e;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) model_votes[i] = 0;
    model_cnt = 0;
  endtask

  // Drives one beat across a rising edge and records it in the vote model;
  // the eighth beat of a frame pushes the expected decision.
  task automatic send_beat(input logic [3:0] b);
    in_valid = 1'b1;
    in_bits  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) model_votes[i] += int'(b[i]);
    model_cnt++;
    if (model_cnt == 8) begin
      sb.push_back(model_decision());
      model_clear();
    end
  endtask

  task automatic send_frame(input logic [3:0] b, input int n);
    for (int k = 0; k < n; k++) send_beat(b);
  endtask

  task automatic wait_valid(output bit ok);
    for (int c = 0; c < 20 && out_valid !== 1'b1; c++) begin
      @(posedge clk);
      #1;
    end
    ok = (out_valid === 1'b1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    tests_run++;
    if ({out_valid, out_class, out_count, out_tie} !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got valid=%b class=%0d count=%0d tie=%b, need all 0",
               out_valid, out_class, out_count, out_tie);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_in_ready: got %b, need 1", in_ready);
    end
  endtask

  task automatic test_single_class();
    exp_t e;
    out_ready = 1'b1;
    send_frame(4'b0100, 8);
    tests_run++;
    if (out_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL latency_one: out_valid=%b right after last beat, need 1", out_valid);
    end
    e = sb.pop_front();
    tests_run++;
    if ({out_class, out_count, out_tie} !== e || e !== {2'd2, 4'd8, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL single_class: got %0d/%0d/%b, need %0d/%0d/%b",
               out_class, out_count, out_tie, e.cls, e.cnt, e.tie);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_count !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL after_handshake: got valid=%b ready=%b count=%0d, need 0/1/0",
               out_valid, in_ready, out_count);
    end
  endtask

  task automatic test_mixed_and_tie();
    exp_t e;
    bit   ok;
    send_frame(4'b0011, 4);
    send_frame(4'b0001, 4);
    wait_valid(ok);
    e = sb.pop_front();
    tests_run++;
    if (!ok || {out_class, out_count, out_tie} !== e) begin
      tests_failed++;
      $display("[TB] FAIL mixed_frame: got %0d/%0d/%b valid=%b, need %0d/%0d/%b",
               out_class, out_count, out_tie, out_valid, e.cls, e.cnt, e.tie);
    end
    handshake();
    send_frame(4'b1010, 8);
    wait_valid(ok);
    e = sb.pop_front();
    tests_run++;
    if (!ok || {out_class, out_count, out_tie} !== e || e !== {2'd1, 4'd8, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL tie_frame: got %0d/%0d/%b valid=%b, need %0d/%0d/%b",
               out_class, out_count, out_tie, out_valid, e.cls, e.cnt, e.tie);
    end
    handshake();
  endtask

  task automatic test_all_zero();
    exp_t e;
    bit   ok;
    send_frame(4'b0000, 8);
    wait_valid(ok);
    e = sb.pop_front();
    tests_run++;
    if (!ok || {out_class, out_count, out_tie} !== e || e !== {2'd0, 4'd0, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL all_zero: got %0d/%0d/%b valid=%b, need %0d/%0d/%b",
               out_class, out_count, out_tie, out_valid, e.cls, e.cnt, e.tie);
    end
    handshake();
  endtask

  task automatic test_backpressure();
    exp_t e;
    bit   ok;
    send_frame(4'b0110, 8);
    wait_valid(ok);
    e = sb.pop_front();
    in_valid = 1'b1;
    in_bits  = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      tests_run++;
      if (!ok || out_valid !== 1'b1 || in_ready !== 1'b0 ||
          {out_class, out_count, out_tie} !== e) begin
        tests_failed++;
        $display("[TB] FAIL hold_cycle%0d: got valid=%b ready=%b %0d/%0d/%b, need 1/0 %0d/%0d/%b",
                 c, out_valid, in_ready, out_class, out_count, out_tie, e.cls, e.cnt, e.tie);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL release: got ready=%b valid=%b, need 1/0", in_ready, out_valid);
    end
    // A beat leaking through the handshake cycle would show up as a nonzero count.
    send_frame(4'b0000, 8);
    wait_valid(ok);
    e = sb.pop_front();
    tests_run++;
    if (!ok || {out_class, out_count, out_tie} !== e) begin
      tests_failed++;
      $display("[TB] FAIL post_hold_frame: got %0d/%0d/%b valid=%b, need %0d/%0d/%b",
               out_class, out_count, out_tie, out_valid, e.cls, e.cnt, e.tie);
    end
    handshake();
  endtask

  task automatic test_clear();
    exp_t e;
    bit   ok;
    send_frame(4'b0001, 5);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_bits  = 4'b0001;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    model_clear();
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL clear_state: got ready=%b valid=%b, need 1/0", in_ready, out_valid);
    end
    send_frame(4'b1000, 8);
    wait_valid(ok);
    e = sb.pop_front();
    tests_run++;
    if (!ok || {out_class, out_count, out_tie} !== e || e !== {2'd3, 4'd8, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL after_clear: got %0d/%0d/%b valid=%b, need %0d/%0d/%b",
               out_class, out_count, out_tie, out_valid, e.cls, e.cnt, e.tie);
    end
    // Clearing a pending decision drops it without a handshake.
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || {out_class, out_count, out_tie} !== 7'd0) begin
      tests_failed++;
      $display("[TB] FAIL clear_in_hold: got valid=%b %0d/%0d/%b, need 0 0/0/0",
               out_valid, out_class, out_count, out_tie);
    end
  endtask

  task automatic test_reset_in_hold();
    exp_t e;
    bit   ok;
    send_frame(4'b0010, 8);
    wait_valid(ok);
    void'(sb.pop_front());
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if (!ok || out_valid !== 1'b0 || {out_class, out_count, out_tie} !== 7'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_in_hold: got valid=%b %0d/%0d/%b (held=%b), need 0 0/0/0",
               out_valid, out_class, out_count, out_tie, ok);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    send_frame(4'b0100, 8);
    wait_valid(ok);
    e = sb.pop_front();
    tests_run++;
    if (!ok || {out_class, out_count, out_tie} !== e) begin
      tests_failed++;
      $display("[TB] FAIL after_reset_frame: got %0d/%0d/%b valid=%b, need %0d/%0d/%b",
               out_class, out_count, out_tie, out_valid, e.cls, e.cnt, e.tie);
    end
    handshake();
  endtask

  // Scenario sequence.
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_bits   = 4'b0000;
    out_ready = 1'b0;
    model_clear();
    test_reset();
    test_single_class();
    test_mixed_and_tie();
    test_all_zero();
    test_backpressure();
    test_clear();
    test_reset_in_hold();
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL scoreboard_drain: %0d decisions left, need 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bnn_vote_accumulator.md
BNN_VOTE_ACCUMULATOR -- requirements
Module: bnn_vote_accumulator

Interface
REQ-001 Parameter NUM_NEURONS, default 4: number of neuron output bits consumed per sample.
REQ-002 Parameter FRAME_LEN, default 8: number of samples accumulated per decision; legal range 2..15.
REQ-003 Parameter CNT_W, default 4: counter width, SHALL equal clog2(FRAME_LEN+1).
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 clear  input  1  synchronous frame abort.
REQ-007 in_valid  input  1  in_bits holds a valid neuron-output sample.
REQ-008 in_ready  output  1  block accepts a sample this cycle.
REQ-009 in_bits  input  NUM_NEURONS  neuron outputs, bit i = neuron i fired.
REQ-010 out_valid  output  1  decision available.
REQ-011 out_ready  input  1  consumer accepts the decision.
REQ-012 out_class  output  clog2(NUM_NEURONS)  index of winning neuron.
REQ-013 out_count  output  CNT_W  vote count of winner.
REQ-014 out_tie  output  1  another neuron has a count equal to the winner's.

Function
REQ-015 Two states SHALL exist: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-016 A beat is accepted when in_valid&&in_ready; on acceptance, vote[i] += in_bits[i] for every i, and sample_cnt += 1.
REQ-017 A beat accepted with sample_cnt==FRAME_LEN-1 SHALL move the FSM to HOLD; out_valid rises the next cycle (latency 1 from the last beat).
REQ-018 In HOLD, out_class/out_count/out_tie SHALL reflect the argmax of the final vote counts, including the last beat, and SHALL remain stable until handshake.
REQ-019 Argmax tie-break: the lowest index wins; out_tie=1 iff any other index equals the maximum.
REQ-020 All-zero votes: out_class=0, out_count=0, out_tie=1 (NUM_NEURONS>1).
REQ-021 On out_valid&&out_ready, votes and sample_cnt SHALL clear and the FSM returns to ACCUM; no input beat is accepted in that same cycle.
REQ-022 In HOLD, in_valid is ignored; no counter changes (backpressure).
REQ-023 clear SHALL have priority over all other events: it zeros votes and sample_cnt and forces ACCUM next cycle, discarding any same-cycle beat or pending decision.
REQ-024 Counters SHALL never wrap: the maximum vote equals FRAME_LEN, which fits in CNT_W.
REQ-025 Outputs in ACCUM: out_class, out_count and out_tie SHALL be driven to 0.

Reset
REQ-026 While reset is asserted: state=ACCUM, votes=0, sample_cnt=0, out_valid=0, in_ready=1 after deassertion, out_class=0, out_count=0, out_tie=0.
REQ-027 Reset mid-frame or in HOLD SHALL discard the partial frame or pending decision with no output handshake.

Structure
REQ-028 Shared package bnn_pkg SHALL hold NUM_NEURONS, FRAME_LEN, CNT_W and the state enum {ACCUM, HOLD}, shared with the neuron core.
REQ-029 A combinational sub-module bnn_argmax SHALL compute class, max count and tie from the vote vector; the FSM and counters stay in the top module.
REQ-030 Outputs out_valid and in_ready SHALL be decoded from the state register only (no combinational path from out_ready).

Verification
REQ-031 8 beats of in_bits=4'b0100, out_ready=1 -> out_valid one cycle after the 8th beat, out_class=2, out_count=8, out_tie=0.
REQ-032 4 beats of 4'b0011 then 4 beats of 4'b0001 -> class 0, count 8, tie 0; then 8 beats of 4'b1010 -> class 1, count 8, tie 1.
REQ-033 8 beats of 4'b0000 -> class 0, count 0, tie 1.
REQ-034 Full frame with out_ready=0 for 5 cycles and in_valid held 1 -> outputs stable, in_ready=0, no counts change; the handshake on cycle 6 restores in_ready=1 the following cycle.
REQ-035 clear asserted after beat 5 (with a simultaneous valid beat) -> that beat is discarded; the next 8 beats of 4'b1000 -> class 3, count 8.
REQ-036 reset pulse while in HOLD -> out_valid=0 immediately, all counts 0, and the next frame decodes correctly.
